fpmult_out_stage: RTL and testbench
===================================

# fpmult_out_stage

Output buffering stage placed directly downstream of the single-cycle FP32 multiplier. It captures each 32-bit product and its 5-bit IEEE754 flag vector through a valid/ready handshake and holds them in a small FIFO. The consumer can then accept products at its own rate. The block also keeps a sticky accumulation of all exception flags and a saturating count of exceptional products, for status readout by the control path.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of exception counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- in_valid  input  1  multiplier product valid.
- in_result  input  32  FP32 product.
- in_flags  input  5  flags: [4] invalid, [3] divide-by-zero, [2] overflow, [1] underflow, [0] inexact.
- in_ready  output  1  stage can accept a product this cycle.
- out_valid  output  1  head entry valid.
- out_result  output  32  head product.
- out_flags  output  5  head flags.
- out_ready  input  1  consumer accepts head.
- flags_clr  input  1  clears sticky flags and the exception counter.
- sticky_flags  output  5  OR of flags of all pushed entries since last clear/reset.
- exc_count  output  CNT_W  count of pushed entries with any of in_flags[4:2] set; saturates at all-ones.
- level  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- in_ready = (level != DEPTH). When full, no push occurs, even if a pop happens in the same cycle.
- out_valid = (level != 0). out_result and out_flags always show the head entry; they are don't-care when empty.
- Push and pop in the same cycle (not full, not empty): level is unchanged, and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Upstream holds in_result and in_flags stable while in_valid && !in_ready. The stage never drops an entry.
- On each push: sticky_flags |= in_flags. If in_flags[4:2] != 0 and exc_count is not all-ones, exc_count += 1.
- flags_clr takes priority. If it is high in the same cycle as a push, sticky_flags <= in_flags and exc_count <= (in_flags[4:2]!=0). Push data still enters the FIFO. flags_clr does not affect FIFO contents.
- No state machine beyond the occupancy counter: the control state is the level value (EMPTY = 0, PARTIAL, FULL = DEPTH).

## Timing
- Reset (rst=0, asynchronous): write pointer = read pointer = 0, level = 0, out_valid = 0, in_ready = 1, sticky_flags = 0, exc_count = 0. Storage array is not reset.
- Deassertion of rst must be synchronised externally. The first push can occur on the first rising edge with rst=1.
- Latency: a product pushed at edge N is visible on out_valid/out_result after edge N. There is no combinational fall-through from in_* to out_*.
- in_ready and out_valid are functions of registered level only. There are no combinational paths in_valid→in_ready or out_ready→out_valid.
- sticky_flags and exc_count update on the push edge and are visible the following cycle.
- Reset mid-operation discards all entries; out_valid falls immediately (asynchronously).

## Structure
- Shared package fpmult_pkg: flag bit index constants (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0), FP32 width constant 32, flag width 5.
- One natural sub-module: fpmult_sync_fifo, a generic DEPTH×37 synchronous FIFO holding {flags, result} with level and full/empty. The top level adds the sticky and counter logic.
- Top wraps FPMult_single output directly: in_result ← result, in_flags ← flags.

## Test plan
- Reset then 4 pushes of 0x3F800000/flags 0, 0x40000000, 0x40400000, 0x40800000 with out_ready=0 → level=4, in_ready=0. A 5th in_valid is held, not accepted.
- From full, out_ready=1 for 4 cycles → outputs appear in order 0x3F800000..0x40800000, then out_valid=0 and level=0.
- Continuous in_valid/out_ready=1 over 20 products → level stays 1, and all 20 emerge in order with a 1-cycle delay, crossing pointer wrap.
- Push flags 5'b00001, then 5'b00100, then 5'b10000 → sticky_flags=5'b10101, exc_count=2.
- flags_clr together with a push of flags 5'b01000 → sticky_flags=5'b01000, exc_count=1, and the entry is present in the FIFO.
- Assert rst=0 mid-stream with level=3 → out_valid=0, level=0, sticky_flags=0, exc_count=0 immediately. With CNT_W=2, four overflow pushes → exc_count saturates at 3.

Source files
------------

// File: rtl/fpmult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_pkg
// Purpose  : Shared FP32 multiplier widths and IEEE754 flag bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package fpmult_pkg;
  localparam int FP_W   = 32;
  localparam int FLAG_W = 5;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam int ENTRY_W = FP_W + FLAG_W;
endpackage : fpmult_pkg
`default_nettype wire

// File: rtl/fpmult_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_sync_fifo
// Purpose  : Generic power-of-two synchronous FIFO with occupancy level.
// Revision : 1.0 - initial release
// ============================================================================
module fpmult_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign o_full  = (r_level == C_FULL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : fpmult_sync_fifo
`default_nettype wire

// File: rtl/fpmult_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_out_stage
// Purpose  : FP32 multiplier output buffer with sticky flags and exception count.
// Revision : 1.0 - initial release
// ============================================================================
module fpmult_out_stage
  import fpmult_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FP_W-1:0]   in_result,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              in_ready,
  output logic              out_valid,
  output logic [FP_W-1:0]   out_result,
  output logic [FLAG_W-1:0] out_flags,
  input  logic              out_ready,
  input  logic              flags_clr,
  output logic [FLAG_W-1:0] sticky_flags,
  output logic [CNT_W-1:0]  exc_count,
  output logic [LVL_W-1:0]  level
);

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_exc;
  logic [ENTRY_W-1:0]  w_head;
  logic [FLAG_W-1:0]   r_sticky;
  logic [CNT_W-1:0]    r_exc_cnt;

  fpmult_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  ({in_flags, in_result}),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign out_result = w_head[FP_W-1:0];
  assign out_flags  = w_head[ENTRY_W-1:FP_W];

  assign w_push = in_valid && in_ready;
  // Only invalid, divide-by-zero and overflow count as exceptional.
  assign w_exc  = |in_flags[FLG_NV:FLG_OF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky  <= '0;
      r_exc_cnt <= '0;
    end else if (flags_clr) begin
      r_sticky  <= w_push ? in_flags : '0;
      r_exc_cnt <= (w_push && w_exc) ? CNT_W'(1) : '0;
    end else if (w_push) begin
      r_sticky <= r_sticky | in_flags;
      if (w_exc && (r_exc_cnt != '1)) begin
        r_exc_cnt <= r_exc_cnt + CNT_W'(1);
      end
    end
  end

  assign sticky_flags = r_sticky;
  assign exc_count    = r_exc_cnt;

endmodule : fpmult_out_stage
`default_nettype wire

// File: tb/tb_fpmult_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmult_out_stage
// Purpose  : Directed self-checking bench for fpmult_out_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpmult_out_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic [4:0]  in_flags;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        out_ready;
  logic        flags_clr;
  logic [4:0]  sticky_flags;
  logic [15:0] exc_count;
  logic [2:0]  level;

  logic        s_in_valid;
  logic [4:0]  s_in_flags;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_result;
  logic [4:0]  s_out_flags;
  logic [4:0]  s_sticky;
  logic [1:0]  s_exc;
  logic [2:0]  s_level;

  int checks;
  int errors;

  fpmult_out_stage #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_ready    (out_ready),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .exc_count    (exc_count),
    .level        (level)
  );

  fpmult_out_stage #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (s_in_valid),
    .in_result    (32'h7F80_0000),
    .in_flags     (s_in_flags),
    .in_ready     (s_in_ready),
    .out_valid    (s_out_valid),
    .out_result   (s_out_result),
    .out_flags    (s_out_flags),
    .out_ready    (1'b1),
    .flags_clr    (1'b0),
    .sticky_flags (s_sticky),
    .exc_count    (s_exc),
    .level        (s_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_result = '0; in_flags = '0;
    out_ready = 1'b0; flags_clr = 1'b0;
    s_in_valid = 1'b0; s_in_flags = '0;
    #2;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (sticky_flags !== 5'd0) begin errors++; $display("FAIL reset_sticky got %b exp 00000", sticky_flags); end
    checks++; if (exc_count !== 16'd0) begin errors++; $display("FAIL reset_exc got %0d exp 0", exc_count); end
    tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] vals [4];
    vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
    vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = vals[i]; in_flags = '0;
      tick();
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    checks++; if (out_result !== 32'h3F80_0000) begin errors++; $display("FAIL full_head got %h exp 3f800000", out_result); end
    // Fifth product held while full must not be accepted.
    in_valid = 1'b1; in_result = 32'h40A0_0000;
    tick();
    tick();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL held_level got %0d exp 4", level); end
    checks++; if (out_result !== 32'h3F80_0000) begin errors++; $display("FAIL held_head got %h exp 3f800000", out_result); end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [31:0] vals [4];
    vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
    vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== vals[i]) begin
        errors++; $display("FAIL drain[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_result, vals[i]);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b exp 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d exp 0", level); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_result = 32'h1000_0000 + 32'(k); in_flags = '0;
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h1000_0000 + 32'(k - 1)) begin
          errors++; $display("FAIL stream[%0d] got v=%b %h exp v=1 %h", k - 1, out_valid, out_result, 32'h1000_0000 + 32'(k - 1));
        end
      end
      tick();
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL stream_level[%0d] got %0d exp 1", k, level); end
    end
    in_valid = 1'b0;
    checks++; if (out_result !== 32'h1000_0013) begin errors++; $display("FAIL stream_last got %h exp 10000013", out_result); end
    tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL stream_end_level got %0d exp 0", level); end
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    checks++; if (sticky_flags !== 5'd0) begin errors++; $display("FAIL sticky_pre got %b exp 00000", sticky_flags); end
    in_valid = 1'b1; in_result = 32'h0000_0001; in_flags = 5'b00001;
    tick();
    checks++; if (sticky_flags !== 5'b00001 || exc_count !== 16'd0) begin errors++; $display("FAIL sticky_nx got %b/%0d exp 00001/0", sticky_flags, exc_count); end
    in_flags = 5'b00100;
    tick();
    in_flags = 5'b10000;
    tick();
    in_valid = 1'b0; in_flags = '0;
    checks++; if (sticky_flags !== 5'b10101) begin errors++; $display("FAIL sticky_acc got %b exp 10101", sticky_flags); end
    checks++; if (exc_count !== 16'd2) begin errors++; $display("FAIL exc_acc got %0d exp 2", exc_count); end
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL clr_pre_level got %0d exp 0", level); end
    in_valid = 1'b1; in_result = 32'h1234_5678; in_flags = 5'b01000; flags_clr = 1'b1;
    tick();
    in_valid = 1'b0; in_flags = '0;
    checks++; if (sticky_flags !== 5'b01000) begin errors++; $display("FAIL clr_push_sticky got %b exp 01000", sticky_flags); end
    checks++; if (exc_count !== 16'd1) begin errors++; $display("FAIL clr_push_exc got %0d exp 1", exc_count); end
    checks++;
    if (level !== 3'd1 || out_result !== 32'h1234_5678 || out_flags !== 5'b01000) begin
      errors++; $display("FAIL clr_push_entry got %0d %h %b exp 1 12345678 01000", level, out_result, out_flags);
    end
    tick();
    flags_clr = 1'b0;
    checks++; if (sticky_flags !== 5'd0 || exc_count !== 16'd0) begin errors++; $display("FAIL clr_only got %b/%0d exp 00000/0", sticky_flags, exc_count); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL clr_only_level got %0d exp 1", level); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'hC000_0000; in_flags = 5'b00100;
    tick();
    tick();
    in_valid = 1'b0; in_flags = '0;
    checks++; if (level !== 3'd3 || exc_count !== 16'd2) begin errors++; $display("FAIL mid_pre got %0d/%0d exp 3/2", level, exc_count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_rst_fifo got %b/%0d exp 0/0", out_valid, level); end
    checks++; if (sticky_flags !== 5'd0 || exc_count !== 16'd0) begin errors++; $display("FAIL mid_rst_stat got %b/%0d exp 00000/0", sticky_flags, exc_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    s_in_valid = 1'b1; s_in_flags = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_exc !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, s_exc, exp_cnt[i]); end
    end
    s_in_valid = 1'b0;
    checks++; if (s_sticky !== 5'b00100) begin errors++; $display("FAIL sat_sticky got %b exp 00100", s_sticky); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_sticky();
    test_clear();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule : tb_fpmult_out_stage
`default_nettype wire
